// File: rtl/lcd_pattern_source.sv
// lcd_pattern_source: test-pattern pixel source feeding the LCD data controller.
// Produces 24-bit RGB for the coordinate currently presented by the controller,
// one Clock after the coordinate changes. Pattern selection, frame counter and
// bouncing-box motion update together on the last pixel of each frame.
//
// Ports:
//   Clock, Reset        50 MHz clock, synchronous active-high reset
//   iClock_en           25 MHz pixel enable (alternate cycles)
//   iCoord_X/Y          active-area coordinates from the controller
//   iH_Count/iV_Count   raw counts, used only to detect the frame boundary
//   iMode               requested pattern (0 bars, 1 box, 2 checker, 3 gradient)
//   iSpeed              box step in pixels per frame
//   oRed/oGreen/oBlue   pixel colour
//   oMode               pattern currently displayed
//   oFrame_count        completed-frame counter
module lcd_pattern_source #(
  parameter int unsigned H_LINE    = 1056,
  parameter int unsigned V_LINE    = 525,
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned BOX_SIZE  = 64,
  parameter int unsigned BAR_WIDTH = 100
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iClock_en,
  input  logic [9:0]  iCoord_X,
  input  logic [9:0]  iCoord_Y,
  input  logic [10:0] iH_Count,
  input  logic [9:0]  iV_Count,
  input  logic [1:0]  iMode,
  input  logic [3:0]  iSpeed,
  output logic [7:0]  oRed,
  output logic [7:0]  oGreen,
  output logic [7:0]  oBlue,
  output logic [1:0]  oMode,
  output logic [15:0] oFrame_count
);

  localparam int unsigned X_LIM = H_ACTIVE - BOX_SIZE;
  localparam int unsigned Y_LIM = V_ACTIVE - BOX_SIZE;

  typedef enum logic [1:0] {
    S_BARS  = 2'd0,
    S_BOX   = 2'd1,
    S_CHECK = 2'd2,
    S_GRAD  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] frame_q, frame_d;
  logic [9:0]  box_x_q, box_x_d;
  logic [9:0]  box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d;   // 1 = moving right
  logic        dir_y_q, dir_y_d;   // 1 = moving down
  logic [23:0] rgb_q, rgb_d;

  logic        frame_end_c;
  logic [10:0] step_x_c, step_y_c;
  logic [2:0]  bar_idx_c;
  logic        active_c, in_box_c, check_c;
  logic [23:0] pixel_c;

  // One axis of box motion; returns {new_forward_dir, new_position}.
  // The 11-bit sum keeps the limit compare free of wrap-around.
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic fwd,
                                            input logic [3:0] spd, input logic [9:0] lim);
    logic [10:0] sum;
    sum = {1'b0, pos} + {7'd0, spd};
    if (fwd) begin
      if (sum >= {1'b0, lim}) step_axis = {1'b0, lim};
      else                    step_axis = {1'b1, sum[9:0]};
    end else begin
      if (pos <= {6'd0, spd}) step_axis = {1'b1, 10'd0};
      else                    step_axis = {1'b0, pos - {6'd0, spd}};
    end
  endfunction

  assign frame_end_c = iClock_en && (iH_Count == 11'(H_LINE - 1)) &&
                       (iV_Count == 10'(V_LINE - 1));

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_BARS;
    else       state_q <= state_d;
  end

  // Next state: requested mode is taken only at the frame boundary
  always_comb begin
    state_d = state_q;
    if (frame_end_c) state_d = state_e'(iMode);
  end

  // Output decode
  always_comb begin
    oMode = state_q;
  end

  // Frame counter and box motion
  always_comb begin
    step_x_c = step_axis(box_x_q, dir_x_q, iSpeed, 10'(X_LIM));
    step_y_c = step_axis(box_y_q, dir_y_q, iSpeed, 10'(Y_LIM));
    frame_d  = frame_q;
    box_x_d  = box_x_q;
    box_y_d  = box_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    if (frame_end_c) begin
      frame_d = frame_q + 16'd1;
      box_x_d = step_x_c[9:0];
      dir_x_d = step_x_c[10];
      box_y_d = step_y_c[9:0];
      dir_y_d = step_y_c[10];
    end
  end

  // Pattern generation for the coordinate currently presented
  always_comb begin
    bar_idx_c = 3'd7;
    // Descending scan: the smallest bar whose upper bound exceeds X wins
    for (int k = 6; k >= 0; k--) begin
      if (iCoord_X < 10'((k + 1) * BAR_WIDTH)) bar_idx_c = 3'(k);
    end
    active_c = (iCoord_X < 10'(H_ACTIVE)) && (iCoord_Y < 10'(V_ACTIVE));
    in_box_c = (iCoord_X >= box_x_q) &&
               ({1'b0, iCoord_X} < ({1'b0, box_x_q} + 11'(BOX_SIZE))) &&
               (iCoord_Y >= box_y_q) &&
               ({1'b0, iCoord_Y} < ({1'b0, box_y_q} + 11'(BOX_SIZE)));
    check_c  = iCoord_X[5] ^ iCoord_Y[5] ^ frame_q[5];
    pixel_c  = 24'h000000;
    if (active_c) begin
      unique case (state_q)
        S_BARS: begin
          unique case (bar_idx_c)
            3'd0: pixel_c = 24'hFFFFFF;
            3'd1: pixel_c = 24'hFFFF00;
            3'd2: pixel_c = 24'h00FFFF;
            3'd3: pixel_c = 24'h00FF00;
            3'd4: pixel_c = 24'hFF00FF;
            3'd5: pixel_c = 24'hFF0000;
            3'd6: pixel_c = 24'h0000FF;
            3'd7: pixel_c = 24'h000000;
          endcase
        end
        S_BOX:   pixel_c = in_box_c ? 24'hFF0000 : 24'h000040;
        S_CHECK: pixel_c = check_c ? 24'hFFFFFF : 24'h000000;
        S_GRAD:  pixel_c = {iCoord_X[9:2], iCoord_Y[8:1], frame_q[7:0]};
      endcase
    end
    // Load on the off-phase so the value is stable when the controller samples
    rgb_d = iClock_en ? rgb_q : pixel_c;
  end

  // Datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      frame_q <= '0;
      box_x_q <= '0;
      box_y_q <= '0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      rgb_q   <= '0;
    end else begin
      frame_q <= frame_d;
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      rgb_q   <= rgb_d;
    end
  end

  assign oRed         = rgb_q[23:16];
  assign oGreen       = rgb_q[15:8];
  assign oBlue        = rgb_q[7:0];
  assign oFrame_count = frame_q;

endmodule
